query_patch_reader: RTL and testbench
=====================================

# query_patch_reader

Read-side sequencer for the query patch memory. On a start pulse it walks a contiguous address range on the memory's read-only port 1 (`csb1`/`addr1`/`rpatch1`). It absorbs the memory's fixed read latency in an in-flight tracker and a small first-word-fall-through buffer, then presents each patch to the compute datapath on a valid/ready stream. It sits between the query patch memory and the ANN distance/search pipeline, and is the consumer counterpart of the I/O loader that fills the memory through port 0.

## Interface
- `DATA_WIDTH`, 11: bits per patch element
- `PATCH_SIZE`, 5: elements per patch
- `ADDR_WIDTH`, 9: memory address width
- `DEPTH`, 512: memory depth in patches; addresses wrap modulo `DEPTH`
- `READ_LATENCY`, 2: cycles from `csb1` low with `addr1` to valid `rpatch1` (SRAM macro plus the memory's output register)
- `FIFO_DEPTH`, 4: output buffer entries; must be ≥ `READ_LATENCY`+2

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  single-cycle request; sampled only in IDLE
- `base_addr`  in  `ADDR_WIDTH`  first patch address; sampled with `start`
- `num_patches`  in  `ADDR_WIDTH`+1  patch count, 0..`DEPTH`; sampled with `start`
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle
- `done`  out  1  single-cycle pulse at end of transfer
- `csb1`  out  1  memory read chip select, active-low
- `addr1`  out  `ADDR_WIDTH`  memory read address
- `rpatch1`  in  `DATA_WIDTH*PATCH_SIZE`  memory read data
- `out_patch`  out  `DATA_WIDTH*PATCH_SIZE`  patch; element 0 in bits [`DATA_WIDTH`-1:0]
- `out_valid`  out  1  `out_patch` valid
- `out_ready`  in  1  downstream accepts; a transfer occurs when `out_valid` and `out_ready` are both high

## Operation
- Reset values: `busy`=0, `done`=0, `csb1`=1, `addr1`=0, `out_valid`=0, `out_patch`=0. Reset also clears the FSM, counters, in-flight pipe and FIFO.
- FSM states:
  - IDLE: on `start`, latch the base address and count.
    - count=0 → DONE.
    - count>0 → READ.
  - READ: issue one read per cycle while credit allows. After the last issue → DRAIN.
  - DRAIN: wait until all issued patches have been handed off downstream → DONE.
  - DONE: assert `done` for one cycle → IDLE.
- Issue rule:
  - `csb1`=0 in a cycle iff state is READ, reads remain, and `inflight + fifo_count < FIFO_DEPTH`. Current counts are used; a same-cycle pop is not credited.
  - `addr1` advances by 1 after each issue and wraps from `DEPTH`-1 to 0.
  - When `csb1`=1, `addr1` holds its last value.
- In-flight tracker: a `READ_LATENCY`-deep valid shift register. When a tagged slot emerges, capture `rpatch1` into the FIFO. Credit accounting guarantees the push never overflows.
- FIFO is first-word-fall-through:
  - `out_valid` = FIFO non-empty.
  - While `out_valid`=1 and `out_ready`=0, `out_patch` is held stable.
  - Push and pop in the same cycle are both honoured.
- Patches are delivered in address order, exactly `num_patches` transfers.
- `start` while `busy` is ignored, with no effect on the current transfer.
- `num_patches`=`DEPTH` reads the whole memory once, starting at `base_addr` and wrapping.
- `rst` mid-transfer aborts immediately:
  - No `done` is produced.
  - Data arriving from reads already in flight is discarded.
  - `csb1` is 1 from the next cycle.

## Timing
- `start` accepted in cycle 0. `busy`=1 and the first `csb1`=0 both occur in cycle 1.
- First `rpatch1` arrives in cycle 1+`READ_LATENCY`, is pushed to the FIFO that cycle, and `out_valid`=1 in cycle 2+`READ_LATENCY` (cycle 4 with defaults).
- With `out_ready` held high, throughput is one patch per cycle, gap-free. N patches finish with the last transfer in cycle N+1+`READ_LATENCY`.
- `done` pulses in the cycle after the final transfer; `busy` falls in the cycle after `done`.
- `num_patches`=0: `done` in cycle 1, no `csb1` activity.
- With `out_ready` low, issue stalls once `inflight + fifo_count` reaches `FIFO_DEPTH`, and resumes the cycle after a pop.

## Structure
- Shared package `query_patch_pkg`:
  - `DATA_WIDTH`, `PATCH_SIZE`, `PATCH_W`=`DATA_WIDTH*PATCH_SIZE`
  - typedef `patch_t` (logic [`PATCH_W`-1:0])
  - FSM state enum `qpr_state_t` {IDLE, READ, DRAIN, DONE}
- One sub-module: `patch_fifo`, a synchronous FWFT FIFO parameterised by width and depth, exposing count/full/empty. The FSM, address counter and in-flight pipe stay in the top module.

## Test plan
- Memory model with `READ_LATENCY`=2, mem[i]=i×3 replicated into all 5 elements. `base_addr`=10, `num_patches`=8, `out_ready`=1 → 8 transfers of addrs 10..17 in cycles 4..11, `done` in cycle 12.
- `base_addr`=508, `num_patches`=6 → `addr1` sequence 508,509,510,511,0,1, and data delivered in that order.
- `out_ready`=0 for 20 cycles after `start`, `num_patches`=10 → exactly 4 reads issued, `out_patch` stable. Releasing `out_ready` → remaining 6 delivered, no loss or duplication.
- Random `out_ready` (50%), `num_patches`=512 → all 512 patches delivered in order. Scoreboard never sees FIFO overflow.
- `num_patches`=0 → `done` in cycle 1, `csb1` stays 1, no `out_valid`. A second `start` while busy is ignored, checked by transfer count.
- `rst` asserted in cycle 3 of a 16-patch transfer → all outputs at reset values next cycle, no `done`. A subsequent `start` runs cleanly.

Source files
------------

// File: rtl/query_patch_pkg.sv
// -----------------------------------------------------------------------------
// query_patch_pkg
// Shared types and constants for the query patch read path.
//   DATA_WIDTH  - bits per patch element
//   PATCH_SIZE  - elements per patch
//   PATCH_W     - packed patch width (element 0 in the low bits)
//   patch_t     - one packed patch
//   qpr_state_t - reader sequencer states
// -----------------------------------------------------------------------------
package query_patch_pkg;

    localparam int DATA_WIDTH = 11;
    localparam int PATCH_SIZE = 5;
    localparam int PATCH_W    = DATA_WIDTH * PATCH_SIZE;

    typedef logic [PATCH_W-1:0] patch_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } qpr_state_t;

endpackage

// File: rtl/query_patch_reader_if.sv
// -----------------------------------------------------------------------------
// query_patch_reader_if
// Bundles the memory read port (csb1/addr1/rpatch1) and the downstream patch
// stream (out_patch/out_valid/out_ready).
//   master : reader side (drives csb1, addr1, out_patch, out_valid)
//   slave  : memory + consumer side (drives rpatch1, out_ready)
// -----------------------------------------------------------------------------
interface query_patch_reader_if #(
    parameter int ADDR_WIDTH = 9
) ();
    import query_patch_pkg::*;

    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    patch_t                rpatch1;
    patch_t                out_patch;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output csb1, addr1, out_patch, out_valid,
        input  rpatch1, out_ready
    );

    modport slave (
        input  csb1, addr1, out_patch, out_valid,
        output rpatch1, out_ready
    );

endinterface

// File: rtl/patch_fifo.sv
// -----------------------------------------------------------------------------
// patch_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on dout
// whenever the FIFO is non-empty; dout reads zero when empty.
//   clk, rst     - clock, synchronous active-high reset (pointers/count only)
//   push, din    - write request and data
//   pop          - consume head entry
//   dout         - head entry
//   count        - occupancy
//   full, empty  - occupancy flags
// Push and pop in the same cycle are both honoured, including when full.
// -----------------------------------------------------------------------------
module patch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= ptr_inc(r_wr);
            if (w_do_pop)  r_rd <= ptr_inc(r_rd);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/query_patch_reader.sv
// -----------------------------------------------------------------------------
// query_patch_reader
// Walks a contiguous (wrapping) address range on the query patch memory's read
// port and streams the patches downstream in address order.
//   clk, rst     - clock, synchronous active-high reset
//   start        - request, sampled only while idle
//   base_addr    - first patch address (sampled with start)
//   num_patches  - patch count 0..DEPTH (sampled with start)
//   busy         - transfer in progress, through the done cycle
//   done         - one-cycle end-of-transfer pulse
//   bus          - memory read port + output stream (master side)
// Reads are issued only while the in-flight reads plus buffered patches leave
// room in the output FIFO, so returning data can always be captured.
// -----------------------------------------------------------------------------
module query_patch_reader
    import query_patch_pkg::*;
#(
    parameter int ADDR_WIDTH   = 9,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_patches,
    output logic                  busy,
    output logic                  done,
    query_patch_reader_if.master  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W = $clog2(2 * FIFO_DEPTH + 1);
    localparam int NUM_W = ADDR_WIDTH + 1;

    qpr_state_t              r_state;
    qpr_state_t              w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [NUM_W-1:0]        r_issue_left;
    logic [NUM_W-1:0]        r_out_left;
    logic [READ_LATENCY-1:0] r_pipe;
    logic [CNT_W-1:0]        w_fifo_count;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [CRD_W-1:0]        w_inflight;
    logic [CRD_W-1:0]        w_credit_used;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_pop;

    // Credit: only current occupancy counts; a pop this cycle frees its slot next cycle.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + CRD_W'(r_pipe[i]);
        end
        w_credit_used = w_inflight + CRD_W'(w_fifo_count);
        w_issue = (r_state == READ) && (r_issue_left != '0) &&
                  (w_credit_used < CRD_W'(FIFO_DEPTH));
    end

    assign w_push = r_pipe[READ_LATENCY-1];
    assign w_pop  = bus.out_valid && bus.out_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (start) w_next = (num_patches == '0) ? DONE : READ;
            READ:  if (w_issue && (r_issue_left == NUM_W'(1))) w_next = DRAIN;
            // Finish once the last outstanding patch is (or is being) handed off.
            DRAIN: if ((r_out_left == '0) || ((r_out_left == NUM_W'(1)) && w_pop)) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = (r_state != IDLE);
        done     = (r_state == DONE);
        bus.csb1 = !w_issue;
    end

    assign bus.addr1 = r_addr;

    // Address/count tracking and the in-flight tag pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_issue_left <= '0;
            r_out_left   <= '0;
            r_pipe       <= '0;
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if ((r_state == IDLE) && start) begin
                r_addr       <= base_addr;
                r_issue_left <= num_patches;
                r_out_left   <= num_patches;
            end else begin
                if (w_issue) begin
                    r_addr       <= (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
                    r_issue_left <= r_issue_left - 1'b1;
                end
                if (w_pop) r_out_left <= r_out_left - 1'b1;
            end
        end
    end

    patch_fifo #(
        .WIDTH (PATCH_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (bus.rpatch1),
        .pop   (w_pop),
        .dout  (bus.out_patch),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign bus.out_valid = !w_fifo_empty;

    // Returning data must always find room in the buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_query_patch_reader.sv
module tb_query_patch_reader;
    import query_patch_pkg::*;

    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int FD    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_patches;
    logic          busy;
    logic          done;

    query_patch_reader_if #(.ADDR_WIDTH(AW)) bus ();

    query_patch_reader #(
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (2),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .num_patches (num_patches),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // mem[i] = i*3 replicated into every element
    function automatic patch_t exp_patch(input int a);
        logic [DATA_WIDTH-1:0] e;
        e = DATA_WIDTH'(a * 3);
        return {PATCH_SIZE{e}};
    endfunction

    // Memory model: two register stages between address and data
    patch_t s1, s2;
    always @(posedge clk) begin
        if (bus.csb1 === 1'b0) s1 <= exp_patch(int'(bus.addr1));
        s2 <= s1;
    end
    assign bus.rpatch1 = s2;

    // Observation log (absolute cycle numbers)
    patch_t got_d[$];
    int     got_c[$];
    int     iss_a[$];
    int     iss_c[$];
    int     done_cnt  = 0;
    int     done_cyc  = -1;
    int     ovf       = 0;
    int     unstable  = 0;
    int     busy_rise = -1;
    int     busy_fall = -1;

    initial begin : monitor
        int     outst;
        bit     prev_busy;
        bit     prev_hold;
        patch_t prev_p;
        outst = 0; prev_busy = 0; prev_hold = 0; prev_p = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                outst = 0; prev_hold = 0; prev_busy = 0;
            end else begin
                if (prev_hold && (bus.out_valid !== 1'b1 || bus.out_patch !== prev_p)) unstable++;
                if (bus.csb1 === 1'b0) begin
                    if (outst >= FD) ovf++;
                    iss_a.push_back(int'(bus.addr1));
                    iss_c.push_back(cyc);
                    outst++;
                end
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    got_d.push_back(bus.out_patch);
                    got_c.push_back(cyc);
                    outst--;
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (busy === 1'b1 && !prev_busy) busy_rise = cyc;
                if (busy !== 1'b1 && prev_busy)  busy_fall = cyc - 1;
                prev_busy = (busy === 1'b1);
                prev_hold = (bus.out_valid === 1'b1 && bus.out_ready !== 1'b1);
                prev_p    = bus.out_patch;
            end
        end
    end

    task automatic do_start(input int b, input int n);
        @(posedge clk); #1;
        start       = 1'b1;
        base_addr   = AW'(b);
        num_patches = (AW+1)'(n);
        t0          = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; num_patches = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)          begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (bus.csb1 !== 1'b1)      begin bad++; $display("FAIL reset_csb1 got=%b exp=1", bus.csb1); end
        total++; if (bus.addr1 !== '0)       begin bad++; $display("FAIL reset_addr1 got=%0d exp=0", bus.addr1); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_patch !== '0)   begin bad++; $display("FAIL reset_out_patch got=%h exp=0", bus.out_patch); end
        rst = 1'b0;
    endtask

    task automatic test_stream_timing();
        int b, n, i0, x0, d0;
        bit ok;
        for (int r = 0; r < 4; r++) begin
            b = (r == 0) ? 10 : int'($urandom_range(0, DEPTH - 1));
            n = (r == 0) ? 8  : int'($urandom_range(1, 40));
            bus.out_ready = 1'b1;
            i0 = iss_a.size(); x0 = got_d.size(); d0 = done_cnt;
            do_start(b, n);
            wait_done(d0, 300, 1'b0, ok);
            total++; if (!ok) begin bad++; $display("FAIL stream_timeout run=%0d got=no_done exp=done", r); end
            total++; if (got_d.size() - x0 !== n) begin bad++; $display("FAIL stream_count got=%0d exp=%0d", got_d.size() - x0, n); end
            for (int k = 0; k < n; k++) begin
                total++;
                if (got_d[x0+k] !== exp_patch((b + k) % DEPTH)) begin
                    bad++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, got_d[x0+k], exp_patch((b + k) % DEPTH));
                end
                total++;
                if (got_c[x0+k] - t0 !== 4 + k) begin
                    bad++; $display("FAIL stream_xfer_cycle k=%0d got=%0d exp=%0d", k, got_c[x0+k] - t0, 4 + k);
                end
            end
            total++; if (done_cyc - t0 !== n + 4) begin bad++; $display("FAIL stream_done_cycle got=%0d exp=%0d", done_cyc - t0, n + 4); end
            total++; if (iss_c[i0] - t0 !== 1)    begin bad++; $display("FAIL stream_first_issue got=%0d exp=1", iss_c[i0] - t0); end
            total++; if (busy_rise - t0 !== 1)    begin bad++; $display("FAIL stream_busy_rise got=%0d exp=1", busy_rise - t0); end
            total++; if (busy_fall !== done_cyc)  begin bad++; $display("FAIL stream_busy_fall got=%0d exp=%0d", busy_fall, done_cyc); end
            total++; if (done_cnt !== d0 + 1)     begin bad++; $display("FAIL stream_done_count got=%0d exp=%0d", done_cnt, d0 + 1); end
        end
    endtask

    task automatic test_wrap();
        int i0, x0, d0;
        bit ok;
        bus.out_ready = 1'b1;
        i0 = iss_a.size(); x0 = got_d.size(); d0 = done_cnt;
        do_start(508, 6);
        wait_done(d0, 100, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout got=no_done exp=done"); end
        total++; if (iss_a.size() - i0 !== 6) begin bad++; $display("FAIL wrap_issue_count got=%0d exp=6", iss_a.size() - i0); end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (iss_a[i0+k] !== (508 + k) % DEPTH) begin
                bad++; $display("FAIL wrap_addr k=%0d got=%0d exp=%0d", k, iss_a[i0+k], (508 + k) % DEPTH);
            end
            total++;
            if (got_d[x0+k] !== exp_patch((508 + k) % DEPTH)) begin
                bad++; $display("FAIL wrap_data k=%0d got=%h exp=%h", k, got_d[x0+k], exp_patch((508 + k) % DEPTH));
            end
        end
    endtask

    task automatic test_backpressure();
        int b, i0, x0, d0, u0;
        bit ok;
        b = int'($urandom_range(0, DEPTH - 1));
        bus.out_ready = 1'b0;
        i0 = iss_a.size(); x0 = got_d.size(); d0 = done_cnt; u0 = unstable;
        do_start(b, 10);
        repeat (19) @(posedge clk);
        #1;
        total++; if (iss_a.size() - i0 !== 4)  begin bad++; $display("FAIL bp_issues_stalled got=%0d exp=4", iss_a.size() - i0); end
        total++; if (bus.out_valid !== 1'b1)   begin bad++; $display("FAIL bp_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_patch !== exp_patch(b)) begin bad++; $display("FAIL bp_head got=%h exp=%h", bus.out_patch, exp_patch(b)); end
        total++; if (unstable !== u0)          begin bad++; $display("FAIL bp_stable got=%0d exp=%0d", unstable, u0); end
        bus.out_ready = 1'b1;
        wait_done(d0, 200, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=no_done exp=done"); end
        total++; if (got_d.size() - x0 !== 10) begin bad++; $display("FAIL bp_count got=%0d exp=10", got_d.size() - x0); end
        total++; if (iss_a.size() - i0 !== 10) begin bad++; $display("FAIL bp_issue_total got=%0d exp=10", iss_a.size() - i0); end
        for (int k = 0; k < 10; k++) begin
            total++;
            if (got_d[x0+k] !== exp_patch((b + k) % DEPTH)) begin
                bad++; $display("FAIL bp_data k=%0d got=%h exp=%h", k, got_d[x0+k], exp_patch((b + k) % DEPTH));
            end
        end
    endtask

    task automatic test_random_full();
        int b, x0, d0, u0, o0, i0, errs;
        bit ok;
        b = int'($urandom_range(0, DEPTH - 1));
        x0 = got_d.size(); i0 = iss_a.size(); d0 = done_cnt; u0 = unstable; o0 = ovf;
        bus.out_ready = 1'b0;
        do_start(b, DEPTH);
        wait_done(d0, 5000, 1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_timeout got=no_done exp=done"); end
        total++; if (got_d.size() - x0 !== DEPTH) begin bad++; $display("FAIL full_count got=%0d exp=%0d", got_d.size() - x0, DEPTH); end
        total++; if (iss_a.size() - i0 !== DEPTH) begin bad++; $display("FAIL full_issue_count got=%0d exp=%0d", iss_a.size() - i0, DEPTH); end
        errs = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (got_d[x0+k] !== exp_patch((b + k) % DEPTH)) errs++;
        end
        total++; if (errs !== 0)       begin bad++; $display("FAIL full_order got=%0d_wrong exp=0_wrong", errs); end
        total++; if (ovf !== o0)       begin bad++; $display("FAIL full_overflow got=%0d exp=%0d", ovf, o0); end
        total++; if (unstable !== u0)  begin bad++; $display("FAIL full_stable got=%0d exp=%0d", unstable, u0); end
        total++; if (done_cyc !== got_c[got_c.size()-1] + 1) begin
            bad++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cyc, got_c[got_c.size()-1] + 1);
        end
    endtask

    task automatic test_zero_and_busy_start();
        int b, i0, x0, d0;
        bit ok;
        bus.out_ready = 1'b1;
        i0 = iss_a.size(); x0 = got_d.size(); d0 = done_cnt;
        do_start(int'($urandom_range(0, DEPTH - 1)), 0);
        wait_done(d0, 20, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_timeout got=no_done exp=done"); end
        total++; if (done_cyc - t0 !== 1)     begin bad++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cyc - t0); end
        total++; if (iss_a.size() !== i0)     begin bad++; $display("FAIL zero_issues got=%0d exp=0", iss_a.size() - i0); end
        total++; if (got_d.size() !== x0)     begin bad++; $display("FAIL zero_xfers got=%0d exp=0", got_d.size() - x0); end

        b = int'($urandom_range(0, DEPTH - 1));
        x0 = got_d.size(); d0 = done_cnt;
        do_start(b, 5);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(b + 100); num_patches = (AW+1)'(7);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0, 100, 1'b0, ok);
        repeat (10) @(posedge clk);
        #1;
        total++; if (!ok) begin bad++; $display("FAIL busy_start_timeout got=no_done exp=done"); end
        total++; if (got_d.size() - x0 !== 5) begin bad++; $display("FAIL busy_start_xfers got=%0d exp=5", got_d.size() - x0); end
        total++; if (done_cnt !== d0 + 1)     begin bad++; $display("FAIL busy_start_dones got=%0d exp=%0d", done_cnt, d0 + 1); end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_d[x0+k] !== exp_patch((b + k) % DEPTH)) begin
                bad++; $display("FAIL busy_start_data k=%0d got=%h exp=%h", k, got_d[x0+k], exp_patch((b + k) % DEPTH));
            end
        end
    endtask

    task automatic test_abort();
        int b, x0, d0;
        bit ok;
        bus.out_ready = 1'b1;
        x0 = got_d.size(); d0 = done_cnt;
        do_start(int'($urandom_range(0, DEPTH - 1)), 16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)          begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
        total++; if (bus.csb1 !== 1'b1)      begin bad++; $display("FAIL abort_csb1 got=%b exp=1", bus.csb1); end
        total++; if (bus.addr1 !== '0)       begin bad++; $display("FAIL abort_addr1 got=%0d exp=0", bus.addr1); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_patch !== '0)   begin bad++; $display("FAIL abort_out_patch got=%h exp=0", bus.out_patch); end
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (done_cnt !== d0)     begin bad++; $display("FAIL abort_no_done got=%0d exp=%0d", done_cnt, d0); end
        total++; if (got_d.size() !== x0) begin bad++; $display("FAIL abort_no_xfer got=%0d exp=0", got_d.size() - x0); end

        b = int'($urandom_range(0, DEPTH - 1));
        x0 = got_d.size(); d0 = done_cnt;
        do_start(b, 5);
        wait_done(d0, 100, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_restart_timeout got=no_done exp=done"); end
        total++; if (got_d.size() - x0 !== 5) begin bad++; $display("FAIL abort_restart_count got=%0d exp=5", got_d.size() - x0); end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_d[x0+k] !== exp_patch((b + k) % DEPTH)) begin
                bad++; $display("FAIL abort_restart_data k=%0d got=%h exp=%h", k, got_d[x0+k], exp_patch((b + k) % DEPTH));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream_timing();
        test_wrap();
        test_backpressure();
        test_random_full();
        test_zero_and_busy_start();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
